// File: rtl/ccff_loader.sv
// Configuration-chain loader: serialises a word stream LSB-first onto ccff_head
// for exactly CHAIN_LEN gated prog_clk edges, optionally comparing ccff_tail.
module ccff_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              verify,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_idx,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int WC_W = $clog2(WORD_W + 1);
    localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              verify_q;
    logic [WORD_W-1:0] buf_q;
    logic [WC_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]  bit_count_q;
    logic              err_q;
    logic [CNT_W-1:0]  err_idx_q;

    logic start_pass;
    logic accept;
    logic shift_en;

    // abort outranks every other event, including the handshake in the same cycle
    assign start_pass = !abort && (state_q == IDLE || state_q == DONE) && start;
    assign accept     = !abort && (state_q == WAIT_WORD) && s_valid;
    assign shift_en   = !abort && (state_q == SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) state_d = WAIT_WORD;
                end
                WAIT_WORD: begin
                    if (s_valid) state_d = SHIFT;
                end
                SHIFT: begin
                    if (bit_count_q == BIT_LAST) begin
                        state_d = DONE;
                    end else if (word_cnt_q == WORD_LAST) begin
                        state_d = WAIT_WORD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: the shift buffer is a plain register, not a memory array, so it is
    // reset along with the rest of the datapath to keep ccff_head defined.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            verify_q    <= 1'b0;
            buf_q       <= '0;
            word_cnt_q  <= '0;
            bit_count_q <= '0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            if (start_pass) begin
                verify_q    <= verify;
                bit_count_q <= '0;
                err_q       <= 1'b0;
                err_idx_q   <= '0;
            end
            if (accept) begin
                buf_q      <= s_data;
                word_cnt_q <= '0;
            end
            if (shift_en) begin
                buf_q       <= buf_q >> 1;
                word_cnt_q  <= word_cnt_q + WC_W'(1);
                bit_count_q <= bit_count_q + CNT_W'(1);
                // only the first mismatch of a pass is recorded
                if (verify_q && !err_q && (ccff_tail != buf_q[0])) begin
                    err_q     <= 1'b1;
                    err_idx_q <= bit_count_q;
                end
            end
        end
    end

    assign s_ready      = !abort && (state_q == WAIT_WORD);
    assign ccff_head    = (state_q == SHIFT) ? buf_q[0] : 1'b0;
    assign chain_clk_en = shift_en;
    assign busy         = (state_q == WAIT_WORD) || (state_q == SHIFT);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign err_idx      = err_idx_q;
    assign bit_count    = bit_count_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader (CHAIN_LEN=40, WORD_W=16) with a 40-bit
// chain model clocked on chain_clk_en.
module tb_ccff_loader;

    localparam int CHAIN_LEN = 40;
    localparam int WORD_W    = 16;
    localparam int CNT_W     = 6;

    logic              prog_clk;
    logic              pReset_n;
    logic              start;
    logic              verify;
    logic              abort;
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              ccff_head;
    logic              chain_clk_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  err_idx;
    logic [CNT_W-1:0]  bit_count;

    ccff_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W)
    ) dut (
        .prog_clk    (prog_clk),
        .pReset_n    (pReset_n),
        .start       (start),
        .verify      (verify),
        .abort       (abort),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .ccff_head   (ccff_head),
        .chain_clk_en(chain_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_idx     (err_idx),
        .bit_count   (bit_count)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Chain model: shifts toward the tail on every enabled edge.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic [CHAIN_LEN-1:0] flip_mask = '0;
    logic                 flip_apply = 1'b0;
    int cyc = 0;
    int en_edges = 0;
    int last_en = 0;
    int hs_count = 0;

    assign ccff_tail = chain[CHAIN_LEN-1];

    always @(posedge prog_clk) begin
        cyc = cyc + 1;
        if (chain_clk_en) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head};
            en_edges = en_edges + 1;
            last_en = cyc;
        end else if (flip_apply) begin
            chain <= chain ^ flip_mask;
        end
        if (s_ready && s_valid) hs_count = hs_count + 1;
    end

    int errors = 0;
    int checks = 0;
    logic gap_bad = 1'b0;
    logic [39:0] stream;
    logic [CHAIN_LEN-1:0] exp_chain;
    int base_en;
    int base_hs;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic v);
        @(negedge prog_clk);
        start  = 1'b1;
        verify = v;
        @(negedge prog_clk);
        start  = 1'b0;
        verify = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
        int n = 0;
        s_data  = w;
        s_valid = (gap == 0);
        while (!s_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        if (!s_ready) begin
            check("ready_timeout", {63'd0, s_ready}, 64'd1);
            s_valid = 1'b0;
            return;
        end
        if (gap > 0) begin
            repeat (gap) begin
                @(negedge prog_clk);
                if (chain_clk_en || !s_ready) gap_bad = 1'b1;
            end
            s_valid = 1'b1;
        end
        @(negedge prog_clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_done_lat"}, 64'(cyc), 64'(last_en));
    endtask

    task automatic flip(input logic [CHAIN_LEN-1:0] m);
        @(negedge prog_clk);
        flip_mask  = m;
        flip_apply = 1'b1;
        @(negedge prog_clk);
        flip_apply = 1'b0;
    endtask

    task automatic wait_bits(input logic [CNT_W-1:0] target);
        int n = 0;
        while (bit_count != target && n < 200) begin
            @(negedge prog_clk);
            n++;
        end
        check("wait_bits", 64'(bit_count), 64'(target));
    endtask

    initial begin
        pReset_n = 1'b1;
        start    = 1'b0;
        verify   = 1'b0;
        abort    = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;

        // stream bit i is the i-th bit shifted; it ends up at chain[39-i]
        stream = 40'h34_0FF0_A5C3;
        for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN-1-i] = stream[i];

        #2 pReset_n = 1'b0;
        #1;
        check("reset_ctl", {58'd0, s_ready, ccff_head, chain_clk_en, busy, done, err}, 64'd0);
        check("reset_cnt", {52'd0, err_idx, bit_count}, 64'd0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        pReset_n = 1'b1;

        // 1: back-to-back load
        base_en = en_edges;
        base_hs = hs_count;
        do_start(1'b0);
        check("s1_wait_word", {62'd0, busy, s_ready}, 64'h3);
        send_word(16'hA5C3, 0);
        send_word(16'h0FF0, 0);
        send_word(16'h1234, 0);
        wait_done("s1");
        check("s1_edges", 64'(en_edges - base_en), 64'd40);
        check("s1_handshakes", 64'(hs_count - base_hs), 64'd3);
        check("s1_chain", 64'(chain), 64'(exp_chain));
        check("s1_bit_count", 64'(bit_count), 64'd40);
        check("s1_done_outs", {61'd0, chain_clk_en, s_ready, busy}, 64'd0);

        // 2: load with 5-cycle valid gaps over an inverted chain
        flip('1);
        base_en = en_edges;
        do_start(1'b0);
        send_word(16'hA5C3, 5);
        send_word(16'h0FF0, 5);
        send_word(16'h1234, 5);
        wait_done("s2");
        check("s2_gap_frozen", {63'd0, gap_bad}, 64'd0);
        check("s2_edges", 64'(en_edges - base_en), 64'd40);
        check("s2_chain", 64'(chain), 64'(exp_chain));

        // 3: verify of a correctly loaded chain
        do_start(1'b1);
        send_word(16'hA5C3, 0);
        send_word(16'h0FF0, 0);
        send_word(16'h1234, 0);
        wait_done("s3");
        check("s3_err", {63'd0, err}, 64'd0);
        check("s3_bit_count", 64'(bit_count), 64'd40);

        // 4: corrupt indices 17 and 30; only the first is reported
        flip((40'd1 << (CHAIN_LEN - 1 - 17)) | (40'd1 << (CHAIN_LEN - 1 - 30)));
        do_start(1'b1);
        send_word(16'hA5C3, 0);
        send_word(16'h0FF0, 0);
        send_word(16'h1234, 0);
        wait_done("s4");
        check("s4_err", {63'd0, err}, 64'd1);
        check("s4_err_idx", 64'(err_idx), 64'd17);
        check("s4_chain_reloaded", 64'(chain), 64'(exp_chain));

        // 5: abort at bit_count 20
        do_start(1'b0);
        check("s5_start_clears", {57'd0, err, bit_count}, 64'd0);
        base_en = en_edges;
        send_word(16'hA5C3, 0);
        send_word(16'h0FF0, 0);
        wait_bits(6'd20);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        check("s5_abort_state", {61'd0, busy, done, chain_clk_en}, 64'd0);
        check("s5_abort_bits", 64'(bit_count), 64'd20);
        check("s5_abort_edges", 64'(en_edges - base_en), 64'd20);
        do_start(1'b0);
        check("s5_restart", {57'd0, busy, bit_count}, 64'h40);

        // 6: start ignored while busy, then async reset mid-SHIFT
        @(negedge prog_clk);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("s6_start_in_wait", {57'd0, s_ready, bit_count}, 64'h40);
        send_word(16'hA5C3, 0);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("s6_start_in_shift", {57'd0, chain_clk_en, bit_count}, 64'h41);
        wait_bits(6'd5);
        #2 pReset_n = 1'b0;
        #1;
        check("s6_reset_ctl", {58'd0, s_ready, ccff_head, chain_clk_en, busy, done, err}, 64'd0);
        check("s6_reset_cnt", {52'd0, err_idx, bit_count}, 64'd0);
        @(negedge prog_clk);
        pReset_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        check("s6_idle_after", {62'd0, busy, done}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
